kb_event_scheduler: RTL and testbench

KB_EVENT_SCHEDULER -- requirements
Module: kb_event_scheduler

---
 rtl/kb_event_scheduler.sv | 148 ++++++++++++++
 tb/tb_kb_event_scheduler.sv | 230 +++++++++++++++++++++++
 2 files changed

// File: rtl/kb_event_scheduler.sv
// PS/2 scan-code front end: detects byte strobes from the receiver and parses
// E0/F0 prefixes into {brk, ext, code} events, which are queued in a FWFT FIFO.
module kb_event_scheduler #(
    parameter int DEPTH = 4
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic [7:0]               kb_data,
    input  logic                     kb_valid,
    input  logic                     rd_en,
    input  logic                     clr_ovf,
    output logic [9:0]               evt_data,
    output logic                     evt_valid,
    output logic [$clog2(DEPTH):0]   evt_count,
    output logic                     full,
    output logic                     overflow,
    output logic                     proto_err
);

    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;

    typedef enum logic [1:0] {
        P_IDLE,
        P_EXT,
        P_BRK,
        P_EXT_BRK
    } parser_state_t;

    logic          sync1_reg;
    logic          sync2_reg;
    logic          prev_reg;
    logic [1:0]    prime_reg;
    logic          arm_reg;
    parser_state_t state_reg;
    logic [AW-1:0] wr_ptr_reg;
    logic [AW-1:0] rd_ptr_reg;
    logic [CW-1:0] count_reg;
    logic          overflow_reg;
    logic          proto_err_reg;
    logic [9:0]    mem [DEPTH];

    logic          strobe;
    logic          is_ext;
    logic          is_brk;
    logic          is_pause;
    logic          is_err;
    logic          is_code;
    logic          push_req;
    logic [9:0]    push_evt;
    logic          pop;
    logic          full_w;
    logic          accept;
    logic          drop;

    // Synchronizer chain. The strobe is only armed once a genuine low level
    // has been seen after reset, so a kb_valid held high through reset is ignored.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sync1_reg <= 1'b0;
            sync2_reg <= 1'b0;
            prev_reg  <= 1'b0;
            prime_reg <= 2'b00;
            arm_reg   <= 1'b0;
        end else begin
            sync1_reg <= kb_valid;
            sync2_reg <= sync1_reg;
            prev_reg  <= sync2_reg;
            prime_reg <= {prime_reg[0], 1'b1};
            arm_reg   <= arm_reg | (prime_reg[1] & ~sync2_reg);
        end
    end

    assign strobe   = sync2_reg & ~prev_reg & arm_reg;

    assign is_ext   = (kb_data == 8'hE0);
    assign is_brk   = (kb_data == 8'hF0);
    assign is_pause = (kb_data == 8'hE1);
    assign is_err   = (kb_data == 8'h00) || (kb_data == 8'hFF);
    assign is_code  = ~(is_ext | is_brk | is_pause | is_err);

    assign push_req = strobe & is_code;
    assign push_evt = {(state_reg == P_BRK) || (state_reg == P_EXT_BRK),
                       (state_reg == P_EXT) || (state_reg == P_EXT_BRK),
                       kb_data};

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_reg <= P_IDLE;
        end else if (strobe) begin
            if (is_ext) begin
                state_reg <= P_EXT;
            end else if (is_brk) begin
                case (state_reg)
                    P_IDLE:  state_reg <= P_BRK;
                    P_EXT:   state_reg <= P_EXT_BRK;
                    default: state_reg <= state_reg;
                endcase
            end else begin
                state_reg <= P_IDLE;
            end
        end
    end

    // A pop frees a slot in the same cycle, so push-while-full succeeds with a pop.
    assign full_w = (count_reg == CW'(DEPTH));
    assign pop    = rd_en & (count_reg != '0);
    assign accept = push_req & (~full_w | pop);
    assign drop   = push_req & full_w & ~pop;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr_reg    <= '0;
            rd_ptr_reg    <= '0;
            count_reg     <= '0;
            overflow_reg  <= 1'b0;
            proto_err_reg <= 1'b0;
        end else begin
            if (accept) begin
                wr_ptr_reg <= wr_ptr_reg + AW'(1);
            end
            if (pop) begin
                rd_ptr_reg <= rd_ptr_reg + AW'(1);
            end
            case ({accept, pop})
                2'b10:   count_reg <= count_reg + CW'(1);
                2'b01:   count_reg <= count_reg - CW'(1);
                default: count_reg <= count_reg;
            endcase
            overflow_reg  <= drop | (overflow_reg & ~clr_ovf);
            proto_err_reg <= (strobe & is_err) | (proto_err_reg & ~clr_ovf);
        end
    end

    always_ff @(posedge clk) begin
        if (accept) begin
            mem[wr_ptr_reg] <= push_evt;
        end
    end

    assign evt_data  = mem[rd_ptr_reg];
    assign evt_valid = (count_reg != '0);
    assign evt_count = count_reg;
    assign full      = full_w;
    assign overflow  = overflow_reg;
    assign proto_err = proto_err_reg;

endmodule

// File: tb/tb_kb_event_scheduler.sv
// Bench for kb_event_scheduler: directed scan-code sequences then random traffic,
// checked against a queue-based model of the prefix parser and event FIFO.
module tb_kb_event_scheduler;

    localparam int DEPTH = 4;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic [7:0] kb_data = 8'h00;
    logic       kb_valid = 1'b0;
    logic       rd_en = 1'b0;
    logic       clr_ovf = 1'b0;
    logic [9:0] evt_data;
    logic       evt_valid;
    logic [$clog2(DEPTH):0] evt_count;
    logic       full;
    logic       overflow;
    logic       proto_err;

    kb_event_scheduler #(.DEPTH(DEPTH)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .kb_data   (kb_data),
        .kb_valid  (kb_valid),
        .rd_en     (rd_en),
        .clr_ovf   (clr_ovf),
        .evt_data  (evt_data),
        .evt_valid (evt_valid),
        .evt_count (evt_count),
        .full      (full),
        .overflow  (overflow),
        .proto_err (proto_err)
    );

    always #5 clk = ~clk;

    int vectors = 0;
    int miscompares = 0;

    // Reference model: pending prefix flags, event queue, sticky flags.
    logic [9:0] q[$];
    bit m_ext = 0;
    bit m_brk = 0;
    bit m_ovf = 0;
    bit m_perr = 0;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        vectors++;
        if (got !== exp) begin
            miscompares++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic check_state(input string tag);
        chk({tag, ".count"}, 32'(evt_count), 32'(q.size()));
        chk({tag, ".valid"}, 32'(evt_valid), 32'(q.size() != 0));
        chk({tag, ".full"}, 32'(full), 32'(q.size() == DEPTH));
        chk({tag, ".overflow"}, 32'(overflow), 32'(m_ovf));
        chk({tag, ".proto_err"}, 32'(proto_err), 32'(m_perr));
        if (q.size() != 0) chk({tag, ".data"}, 32'(evt_data), 32'(q[0]));
    endtask

    task automatic send(input logic [7:0] b, input bit with_pop, input bit with_clr);
        bit push;
        bit err;
        bit was_empty;
        bit pop_ok;
        logic [9:0] ev;
        push = 0;
        err = 0;
        ev = '0;
        case (b)
            8'hE0: begin m_ext = 1; m_brk = 0; end
            8'hF0: m_brk = 1;
            8'hE1: begin m_ext = 0; m_brk = 0; end
            8'h00, 8'hFF: begin err = 1; m_ext = 0; m_brk = 0; end
            default: begin
                push = 1;
                ev = {m_brk, m_ext, b};
                m_ext = 0;
                m_brk = 0;
            end
        endcase
        @(negedge clk);
        kb_data = b;
        kb_valid = 1'b1;
        @(negedge clk);
        @(negedge clk);
        was_empty = (q.size() == 0);
        pop_ok = 0;
        if (with_pop && q.size() != 0) begin
            chk("send.pop_data", 32'(evt_data), 32'(q[0]));
            pop_ok = 1;
        end
        if (push && was_empty) chk("send.pre_valid", 32'(evt_valid), 32'(0));
        rd_en = with_pop;
        clr_ovf = with_clr;
        @(negedge clk);
        rd_en = 1'b0;
        clr_ovf = 1'b0;
        if (with_clr) begin m_ovf = 0; m_perr = 0; end
        if (pop_ok) void'(q.pop_front());
        if (err) m_perr = 1;
        if (push) begin
            if (q.size() < DEPTH) q.push_back(ev);
            else m_ovf = 1;
        end
        if (push && was_empty) chk("send.latency", 32'(evt_valid), 32'(1));
        repeat (2) @(negedge clk);
        kb_valid = 1'b0;
        repeat (4) @(negedge clk);
        check_state($sformatf("send_%02h", b));
        $display("send %02h pop=%0b clr=%0b -> count=%0d", b, with_pop, with_clr, q.size());
    endtask

    task automatic pop_evt();
        @(negedge clk);
        if (q.size() != 0) chk("pop.data", 32'(evt_data), 32'(q[0]));
        rd_en = 1'b1;
        @(negedge clk);
        rd_en = 1'b0;
        if (q.size() != 0) void'(q.pop_front());
        check_state("pop");
        $display("pop -> count=%0d", q.size());
    endtask

    task automatic clear_flags();
        @(negedge clk);
        clr_ovf = 1'b1;
        @(negedge clk);
        clr_ovf = 1'b0;
        m_ovf = 0;
        m_perr = 0;
        check_state("clr");
        $display("clr_ovf");
    endtask

    task automatic do_reset(input bit hold_valid);
        @(negedge clk);
        kb_data = 8'h1C;
        kb_valid = hold_valid;
        rst_n = 1'b0;
        #2;
        q.delete();
        m_ext = 0; m_brk = 0; m_ovf = 0; m_perr = 0;
        check_state("in_reset");
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        repeat (6) @(negedge clk);
        check_state("post_reset");
        kb_valid = 1'b0;
        repeat (4) @(negedge clk);
        $display("reset hold_valid=%0b", hold_valid);
    endtask

    function automatic logic [7:0] rand_code();
        logic [7:0] b;
        do b = 8'($urandom_range(0, 255));
        while (b == 8'h00 || b == 8'hE0 || b == 8'hE1 || b == 8'hF0 || b == 8'hFF);
        return b;
    endfunction

    initial begin
        int r;
        logic [7:0] b;
        repeat (3) @(negedge clk);
        check_state("reset_hold");
        rst_n = 1'b1;
        repeat (4) @(negedge clk);
        check_state("reset_release");

        send(8'h1C, 0, 0);
        pop_evt();
        send(8'hF0, 0, 0); send(8'h1C, 0, 0);
        pop_evt();
        send(8'hE0, 0, 0); send(8'hF0, 0, 0); send(8'h75, 0, 0);
        pop_evt();
        send(8'hE0, 0, 0); send(8'h74, 0, 0);
        pop_evt();
        pop_evt();

        send(8'h15, 0, 0); send(8'h16, 0, 0); send(8'h1E, 0, 0);
        send(8'h26, 0, 0); send(8'h25, 0, 0);
        repeat (4) pop_evt();
        clear_flags();

        send(8'h15, 0, 0); send(8'h16, 0, 0); send(8'h1E, 0, 0);
        send(8'h26, 0, 0); send(8'h25, 1, 0);
        send(8'h33, 0, 1);
        send(8'h34, 0, 1);
        repeat (4) pop_evt();
        clear_flags();

        send(8'hE0, 0, 0);
        do_reset(0);
        send(8'h1C, 0, 0);
        send(8'hFF, 0, 0);
        send(8'h00, 0, 1);
        pop_evt();
        clear_flags();
        do_reset(1);
        send(8'hE1, 0, 0);
        send(8'h2A, 0, 0);
        pop_evt();

        for (int i = 0; i < 400; i++) begin
            r = $urandom_range(0, 99);
            if (r < 55) begin
                r = $urandom_range(0, 99);
                if (r < 20) b = 8'hE0;
                else if (r < 40) b = 8'hF0;
                else if (r < 44) b = 8'hE1;
                else if (r < 47) b = (r[0]) ? 8'h00 : 8'hFF;
                else b = rand_code();
                send(b, $urandom_range(0, 99) < 15, $urandom_range(0, 99) < 10);
            end else if (r < 85) begin
                pop_evt();
            end else if (r < 96) begin
                clear_flags();
            end else begin
                do_reset(1'($urandom_range(0, 1)));
            end
        end

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
